// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C command sequencer.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_BIT, ST_ACK, ST_STOP, ST_GAP, ST_DONE, ST_FAIL
  } state_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider: down-counter, tick on terminal count, reload on clear.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = idx_width(CLK_DIV);
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || (cnt == '0)) begin
      cnt <= TC;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Replays a table of I2C write transactions as bus master, with per-command NACK retry.
//   state | meaning
//   IDLE  | bus released, waiting for i_start
//   START | START condition, 4 quarters
//   BIT   | one data bit, 4 quarters, MSB first
//   ACK   | SDA released, slave ACK sampled at end of q2
//   STOP  | STOP condition, 4 quarters
//   GAP   | GAP_Q idle quarters, then retry / next / done / fail
//   DONE  | one-cycle o_finished pulse
//   FAIL  | one-cycle o_error pulse
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int NUM_CMDS      = 10,
  parameter int BYTES_PER_CMD = 3,
  parameter int CLK_DIV       = 4,
  parameter int MAX_RETRY     = 3,
  parameter int GAP_Q         = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_start,
  input  logic [NUM_CMDS*BYTES_PER_CMD*8-1:0]   i_cmd_table,
  input  logic                                  i_sdat,
  output logic                                  o_sclk,
  output logic                                  o_sdat,
  output logic                                  o_oen,
  output logic                                  o_busy,
  output logic                                  o_finished,
  output logic                                  o_error,
  output logic [idx_width(NUM_CMDS)-1:0]        o_err_index
);

  localparam int TBL_W   = NUM_CMDS * BYTES_PER_CMD * 8;
  localparam int POS_W   = $clog2(TBL_W);
  localparam int CMD_W   = idx_width(NUM_CMDS);
  localparam int BYTE_W  = idx_width(BYTES_PER_CMD);
  localparam int RETRY_W = idx_width(MAX_RETRY + 1);
  localparam int GAP_W   = idx_width(GAP_Q);

  localparam logic [CMD_W-1:0]   LAST_CMD  = CMD_W'(NUM_CMDS - 1);
  localparam logic [BYTE_W-1:0]  LAST_BYTE = BYTE_W'(BYTES_PER_CMD - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]   GAP_TC    = GAP_W'(GAP_Q - 1);

  state_t              state, state_nxt;
  quarter_t            q, q_nxt;
  logic [2:0]          bit_cnt, bit_nxt;
  logic [BYTE_W-1:0]   byte_idx, byte_nxt;
  logic [CMD_W-1:0]    cmd_idx, cmd_nxt;
  logic [RETRY_W-1:0]  retry_cnt, retry_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic                fail_flag, fail_nxt;
  logic                nack_q, nack_nxt;
  logic [TBL_W-1:0]    tbl_q, tbl_nxt;
  logic [CMD_W-1:0]    err_index, err_nxt;

  logic                tick;
  logic                qend;
  logic [POS_W-1:0]    bit_pos;
  logic                cur_bit;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (state == ST_IDLE),
    .tick (tick)
  );

  // Command 0 byte 0 occupies the table MSBs.
  assign bit_pos = POS_W'(TBL_W - 1 - ((int'(cmd_idx) * BYTES_PER_CMD + int'(byte_idx)) * 8
                                       + 7 - int'(bit_cnt)));
  assign cur_bit     = tbl_q[bit_pos];
  assign qend        = tick && (q == Q3);
  assign o_err_index = err_index;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      q         <= Q0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      cmd_idx   <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
      fail_flag <= 1'b0;
      nack_q    <= 1'b0;
      tbl_q     <= '0;
      err_index <= '0;
    end else begin
      state     <= state_nxt;
      q         <= q_nxt;
      bit_cnt   <= bit_nxt;
      byte_idx  <= byte_nxt;
      cmd_idx   <= cmd_nxt;
      retry_cnt <= retry_nxt;
      gap_cnt   <= gap_nxt;
      fail_flag <= fail_nxt;
      nack_q    <= nack_nxt;
      tbl_q     <= tbl_nxt;
      err_index <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    bit_nxt    = bit_cnt;
    byte_nxt   = byte_idx;
    cmd_nxt    = cmd_idx;
    retry_nxt  = retry_cnt;
    gap_nxt    = gap_cnt;
    fail_nxt   = fail_flag;
    nack_nxt   = nack_q;
    tbl_nxt    = tbl_q;
    err_nxt    = err_index;
    o_sclk     = 1'b1;
    o_sdat     = 1'b1;
    o_oen      = 1'b1;
    o_busy     = 1'b1;
    o_finished = 1'b0;
    o_error    = 1'b0;

    if (tick && (state inside {ST_START, ST_BIT, ST_ACK, ST_STOP})) begin
      q_nxt = quarter_t'(q + 2'd1);
    end

    unique case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          tbl_nxt   = i_cmd_table;
          cmd_nxt   = '0;
          retry_nxt = '0;
          err_nxt   = '0;
          fail_nxt  = 1'b0;
          q_nxt     = Q0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        o_sclk = (q != Q3);
        o_sdat = (q == Q0);
        if (qend) begin
          bit_nxt   = 3'd7;
          byte_nxt  = '0;
          state_nxt = ST_BIT;
        end
      end
      ST_BIT: begin
        o_sclk = (q == Q2) || (q == Q3);
        o_sdat = cur_bit;
        if (qend) begin
          if (bit_cnt == 3'd0) state_nxt = ST_ACK;
          else                 bit_nxt   = bit_cnt - 3'd1;
        end
      end
      ST_ACK: begin
        o_sclk = (q == Q2) || (q == Q3);
        o_sdat = SDA_NACK;
        o_oen  = 1'b0;
        if (tick && (q == Q2)) nack_nxt = (i_sdat != SDA_ACK);
        if (qend) begin
          if (nack_q) begin
            fail_nxt  = 1'b1;
            state_nxt = ST_STOP;
          end else if (byte_idx == LAST_BYTE) begin
            state_nxt = ST_STOP;
          end else begin
            byte_nxt  = byte_idx + BYTE_W'(1);
            bit_nxt   = 3'd7;
            state_nxt = ST_BIT;
          end
        end
      end
      ST_STOP: begin
        o_sclk = (q != Q0);
        o_sdat = (q == Q2) || (q == Q3);
        if (qend) begin
          gap_nxt   = GAP_TC;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_cnt != '0) begin
            gap_nxt = gap_cnt - GAP_W'(1);
          end else if (fail_flag && (retry_cnt < RETRY_MAX)) begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            fail_nxt  = 1'b0;
            state_nxt = ST_START;
          end else if (fail_flag) begin
            err_nxt   = cmd_idx;
            state_nxt = ST_FAIL;
          end else if (cmd_idx == LAST_CMD) begin
            state_nxt = ST_DONE;
          end else begin
            cmd_nxt   = cmd_idx + CMD_W'(1);
            retry_nxt = '0;
            state_nxt = ST_START;
          end
        end
      end
      ST_DONE: begin
        o_busy     = 1'b0;
        o_finished = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_FAIL: begin
        o_busy    = 1'b0;
        o_error   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
